// File: rtl/uart_tx_pkg.sv
// UART TX frame sequencer shared types: FSM states and output-mux select codes.
// The select codes are also decoded by the TX output mux.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [1:0] MUX_START = 2'b00;
    localparam logic [1:0] MUX_STOP  = 2'b01;
    localparam logic [1:0] MUX_DATA  = 2'b10;
    localparam logic [1:0] MUX_PAR   = 2'b11;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, data (LSB first), optional parity, stop bits.
// Define UART_TX_STOP2_EN for two stop bits (accept window moves to the 2nd one).
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             DATA_VALID,
    input  logic             PAR_EN,
    output logic             ACCEPT,
    output logic             SER_EN,
    output logic [CNT_W-1:0] BIT_IDX,
    output logic [1:0]       MUX_SEL,
    output logic             BUSY
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             par_en_q, par_en_d;
    logic             last_stop;

`ifdef UART_TX_STOP2_EN
    logic stop_cnt_q, stop_cnt_d;

    assign last_stop = (state_q == S_STOP) && stop_cnt_q;
`else
    assign last_stop = (state_q == S_STOP);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            par_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            par_en_q  <= par_en_d;
        end
    end

`ifdef UART_TX_STOP2_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            stop_cnt_q <= 1'b0;
        end else begin
            stop_cnt_q <= stop_cnt_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = '0;
        par_en_d  = par_en_q;
        SER_EN    = 1'b0;
        MUX_SEL   = MUX_STOP;
        BUSY      = 1'b1;
        BIT_IDX   = bit_cnt_q;
`ifdef UART_TX_STOP2_EN
        stop_cnt_d = 1'b0;
`endif
        ACCEPT = DATA_VALID && !RST
                 && ((state_q == S_IDLE) || last_stop);

        if (ACCEPT) begin
            par_en_d = PAR_EN;
        end

        unique case (state_q)
            S_IDLE: begin
                BUSY = 1'b0;
                if (ACCEPT) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                MUX_SEL = MUX_START;
                state_d = S_DATA;
            end
            S_DATA: begin
                MUX_SEL = MUX_DATA;
                SER_EN  = 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                MUX_SEL = MUX_PAR;
                state_d = S_STOP;
            end
            S_STOP: begin
                if (last_stop) begin
                    state_d = ACCEPT ? S_START : S_IDLE;
                end else begin
`ifdef UART_TX_STOP2_EN
                    stop_cnt_d = 1'b1;
`endif
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: phase table plus a per-cycle output scoreboard.
// Honours UART_TX_STOP2_EN for the expected stop length.
module tb_uart_tx_ctrl;
    import uart_tx_pkg::*;

    localparam int W     = 8;
    localparam int CW    = (W > 1) ? $clog2(W) : 1;
`ifdef UART_TX_STOP2_EN
    localparam int NS    = 2;
`else
    localparam int NS    = 1;
`endif

    logic          CLK;
    logic          RST;
    logic          DATA_VALID;
    logic          PAR_EN;
    logic          ACCEPT;
    logic          SER_EN;
    logic [CW-1:0] BIT_IDX;
    logic [1:0]    MUX_SEL;
    logic          BUSY;

    uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .ACCEPT     (ACCEPT),
        .SER_EN     (SER_EN),
        .BIT_IDX    (BIT_IDX),
        .MUX_SEL    (MUX_SEL),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]    mux;
        logic          ser;
        logic          busy;
        logic [CW-1:0] idx;
    } exp_t;

    typedef struct {
        logic rst;
        logic dv;
        logic pe;
        int   n;
        int   acc;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[18];
    int   total = 0;
    int   bad   = 0;
    int   acc_cnt;
    logic s_busy;
    int   max_idx;
    int   par_cnt;

    function automatic int flen(input logic pe);
        return 1 + W + (pe ? 1 : 0) + NS;
    endfunction

    function automatic exp_t mk(input logic [1:0] m, input logic s,
                                input logic b, input int i);
        exp_t e;
        e.mux  = m;
        e.ser  = s;
        e.busy = b;
        e.idx  = CW'(i);
        return e;
    endfunction

    task automatic push_frame(input logic pe);
        exp_q.push_back(mk(MUX_START, 1'b0, 1'b1, 0));
        for (int i = 0; i < W; i++) exp_q.push_back(mk(MUX_DATA, 1'b1, 1'b1, i));
        if (pe) exp_q.push_back(mk(MUX_PAR, 1'b0, 1'b1, 0));
        for (int i = 0; i < NS; i++) exp_q.push_back(mk(MUX_STOP, 1'b0, 1'b1, 0));
    endtask

    task automatic cyc(input logic rst, input logic dv, input logic pe);
        exp_t cur;
        exp_t got;
        logic acc_exp;
        RST        = rst;
        DATA_VALID = dv;
        PAR_EN     = pe;
        @(negedge CLK);
        cur = (exp_q.size() != 0) ? exp_q[0] : mk(MUX_STOP, 1'b0, 1'b0, 0);
        acc_exp = dv && !rst && ((exp_q.size() == 0) ||
                  (exp_q.size() == 1 && exp_q[0].mux == MUX_STOP));
        got = {MUX_SEL, SER_EN, BUSY, BIT_IDX};
        total++;
        if (got !== cur) begin
            bad++;
            $display("FAIL outs t=%0t got mux/ser/busy/idx=%b expected=%b",
                     $time, got, cur);
        end
        total++;
        if (ACCEPT !== acc_exp) begin
            bad++;
            $display("FAIL accept t=%0t got=%b expected=%b", $time, ACCEPT, acc_exp);
        end
        if (ACCEPT === 1'b1) acc_cnt++;
        s_busy = BUSY;
        if (SER_EN === 1'b1 && int'(BIT_IDX) > max_idx) max_idx = int'(BIT_IDX);
        if (MUX_SEL === MUX_PAR) par_cnt++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (rst) exp_q.delete();
        else if (acc_exp) push_frame(pe);
        @(posedge CLK);
        #1;
    endtask

    task automatic one_frame(input logic pe);
        int busy_n;
        max_idx = 0;
        par_cnt = 0;
        busy_n  = 0;
        cyc(1'b0, 1'b1, pe);
        for (int k = 0; k < 50; k++) begin
            cyc(1'b0, 1'b0, ~pe);
            if (!s_busy) break;
            busy_n++;
        end
        total++;
        if (busy_n != flen(pe)) begin
            bad++;
            $display("FAIL busy_len pe=%b got=%0d expected=%0d", pe, busy_n, flen(pe));
        end
        total++;
        if (max_idx != W - 1) begin
            bad++;
            $display("FAIL max_idx got=%0d expected=%0d", max_idx, W - 1);
        end
        total++;
        if (par_cnt != (pe ? 1 : 0)) begin
            bad++;
            $display("FAIL par_cycles pe=%b got=%0d expected=%0d", pe, par_cnt, pe ? 1 : 0);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 3, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 2, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1, 1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, flen(1'b1), 0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1, 1};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 3, 0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, flen(1'b0) - 3, 0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 2 * flen(1'b1) + 1, 3};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, flen(1'b1), 0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1, 1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 4, 0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 3, 0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 2, 0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1, 1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 2, 0};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 3, 0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, flen(1'b1) - 5, 0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 2, 0};

        RST        = 1'b1;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        @(posedge CLK);
        #1;

        for (int p = 0; p < 18; p++) begin
            acc_cnt = 0;
            for (int c = 0; c < tbl[p].n; c++) cyc(tbl[p].rst, tbl[p].dv, tbl[p].pe);
            total++;
            if (acc_cnt != tbl[p].acc) begin
                bad++;
                $display("FAIL phase%0d_accepts got=%0d expected=%0d",
                         p, acc_cnt, tbl[p].acc);
            end
        end

        one_frame(1'b1);
        one_frame(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
